sync_data_fifo: RTL and testbench

// - Single-clock FIFO buffering FW-wide flits between a producer (spike/config push) and a

---
 rtl/sync_data_fifo.sv | 176 +++++++++++++++++
 tb/tb_sync_data_fifo.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sync_data_fifo.sv
// -----------------------------------------------------------------------------
// sync_data_fifo
//
// Purpose
//   Single-clock FIFO that buffers flits between a producer (spike/config
//   push) and a consumer (flit sender FSM) inside a neuromorphic node.
//   Storage lives in sync_data_fifo_ram, a synchronous dual-port RAM with
//   registered, read-before-write read port. The RAM is also usable on its
//   own, e.g. as a destination table.
//
// Ports (sync_data_fifo)
//   clk          in   1           clock, rising edge
//   rst_n        in   1           asynchronous, active-low reset
//   wr_en        in   1           push din this cycle
//   rd_en        in   1           pop head entry this cycle
//   din          in   DATA_WIDTH  write data
//   dout         out  DATA_WIDTH  read data, valid the cycle after an accepted pop
//   almost_full  out  1           count >= DEPTH-1
//   empty        out  1           count == 0
//
// Ports (sync_data_fifo_ram)
//   clk, wr_en, rd_en, wr_addr, wr_data, rd_addr, rd_data
//
// Configuration
//   DATA_FIFO_CHECK_EN : when defined, simulation-only messages are printed
//                        for writes to a full FIFO and reads from an empty
//                        FIFO. No functional change.
// -----------------------------------------------------------------------------

module sync_data_fifo_ram #(
    parameter int DATA_WIDTH = 59,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // No reset on the array or the read register so the tools can map this
    // onto block RAM.
    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of the array gives read-before-write behaviour on a
    // same-address collision: the old word is returned.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
    end

endmodule

module sync_data_fifo #(
    parameter int DATA_WIDTH = 59,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  almost_full,
    output logic                  empty
);

    localparam int                DEPTH       = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AFULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH - 1);

    // Pointers carry one extra MSB to tell full from empty when the RAM
    // address bits match.
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  rd_seen_q, rd_seen_d;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty_w;
    logic                  rd_accept;
    logic                  wr_accept;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    // ------------------------------------------------------------------
    // Status derived from the registered pointers
    // ------------------------------------------------------------------
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;

    assign empty       = empty_w;
    assign almost_full = (count >= AFULL_LEVEL);

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    // There is no bypass path: a push into an empty FIFO is not visible to
    // a read in the same cycle.
    assign rd_accept = rd_en && !empty_w;
    assign wr_accept = wr_en && (!full || rd_accept);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_seen_d = rd_seen_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            rd_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_seen_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_seen_q <= rd_seen_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    sync_data_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .rd_en   (rd_accept),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (din),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (ram_rd_data)
    );

    // The RAM read register is the dout register (it only loads on an
    // accepted pop, so it holds otherwise). It has no reset, so dout is
    // forced to zero until the first pop after reset; this also makes a
    // mid-stream reset clear dout immediately.
    assign dout = rd_seen_q ? ram_rd_data : '0;

`ifdef DATA_FIFO_CHECK_EN
    always @(posedge clk) begin
        if (rst_n) begin
            if (wr_en && full && !rd_accept) begin
                $display("%t: ERROR: write to full fifo: %m", $time);
            end
            if (rd_en && empty_w) begin
                $display("%t: ERROR: read from empty fifo: %m", $time);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_data_fifo.sv
module tb_sync_data_fifo;

    localparam int DW = 59;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          almost_full;
    logic          empty;

    // standalone RAM instance for the collision check
    logic       r_we, r_re;
    logic [3:0] r_wa, r_ra;
    logic [7:0] r_wd, r_rd;

    int tests_run = 0;
    int tests_failed = 0;

    // scoreboard: words the FIFO should hold, in order, plus expected dout
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_dout;

    always #5 clk = ~clk;

    sync_data_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .din         (din),
        .dout        (dout),
        .almost_full (almost_full),
        .empty       (empty)
    );

    sync_data_fifo_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u_ram_tb (
        .clk     (clk),
        .wr_en   (r_we),
        .rd_en   (r_re),
        .wr_addr (r_wa),
        .wr_data (r_wd),
        .rd_addr (r_ra),
        .rd_data (r_rd)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".dout"}, 64'(dout), 64'(model_dout));
        check({tag, ".empty"}, 64'(empty), 64'(exp_q.size() == 0));
        check({tag, ".afull"}, 64'(almost_full), 64'(exp_q.size() >= 15));
    endtask

    // One clock of stimulus. Called at posedge+1; returns at posedge+1.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
        bit rd_ok, wr_ok;
        wr_en = w;
        rd_en = r;
        din   = d;
        rd_ok = r && (exp_q.size() != 0);
        wr_ok = w && ((exp_q.size() < 16) || rd_ok);
        @(posedge clk);
        if (rd_ok) model_dout = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(d);
        #1;
        check_status(tag);
        $display("[TB] %s wr=%0b rd=%0b din=%0h dout=%0h empty=%0b afull=%0b",
                 tag, w, r, d, dout, empty, almost_full);
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        r_we  = 1'b0;
        r_re  = 1'b0;
        r_wa  = '0;
        r_ra  = '0;
        r_wd  = '0;
        model_dout = '0;

        #2;
        check_status("reset");
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic push/pop of 1..3
        for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, DW'(i), "push");
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, 1'b1, '0, "pop");
            check("pop_value", 64'(dout), 64'(i));
        end

        // read on empty: dout holds; write+read on empty: write only
        cycle(1'b0, 1'b1, '0, "rd_empty");
        check("rd_empty_hold", 64'(dout), 64'h3);
        cycle(1'b1, 1'b1, DW'(59'h55), "wr_rd_empty");
        cycle(1'b0, 1'b1, '0, "pop_55");

        // fill, overflow, simultaneous op while full, drain
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, DW'(100 + i), "fill");
        check("fill_afull", 64'(almost_full), 64'h1);
        cycle(1'b1, 1'b1, DW'(59'hAA), "full_wr_rd");
        check("full_head", 64'(dout), 64'd100);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0, "drain");
        check("drain_last", 64'(dout), 64'hAA);

        // wrap with push/pop pairs, count never above 1
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, DW'(1000 + i), "wrap_push");
            cycle(1'b0, 1'b1, '0, "wrap_pop");
        end
        // simultaneous push/pop at steady state of one entry
        cycle(1'b1, 1'b0, DW'(59'h7_0000_0000_0001), "stream_push");
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 1'b1, {4'h5, 55'(i)}, "stream");

        // asynchronous reset mid-stream
        cycle(1'b1, 1'b0, DW'(59'h123), "pre_rst");
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst_n = 1'b0;
        #2;
        exp_q.delete();
        model_dout = '0;
        check_status("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 1'b1, '0, "post_rst_rd_empty");
        cycle(1'b1, 1'b0, DW'(59'h9), "post_rst_push");
        cycle(1'b0, 1'b1, '0, "post_rst_pop");

        // RAM read-before-write on the same address
        r_we = 1'b1; r_wa = 4'd3; r_wd = 8'h11;
        @(posedge clk); #1;
        r_we = 1'b1; r_wa = 4'd3; r_wd = 8'h22; r_re = 1'b1; r_ra = 4'd3;
        @(posedge clk); #1;
        check("ram_old_word", 64'(r_rd), 64'h11);
        $display("[TB] ram collision rd_data=%0h", r_rd);
        r_we = 1'b0; r_re = 1'b1;
        @(posedge clk); #1;
        check("ram_new_word", 64'(r_rd), 64'h22);
        $display("[TB] ram reread rd_data=%0h", r_rd);
        r_re = 1'b0;
        @(posedge clk); #1;
        check("ram_hold", 64'(r_rd), 64'h22);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
